// File: rtl/ublock_rc_pkg.sv
// Shared types and default constants for the round-constant sequencer.
// Holds the FSM state encoding and the default SEED / TAP_MASK / WORD_XOR.
package ublock_rc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_RUN  = 2'd2
  } rc_state_e;

  localparam logic [7:0]  RC_DEF_SEED     = 8'h6C;
  localparam logic [7:0]  RC_DEF_TAP_MASK = 8'hC6;
  // Top byte belongs to word 3, bottom byte to word 0.
  localparam logic [31:0] RC_DEF_WORD_XOR = {8'h40, 8'h54, 8'h11, 8'h05};

endpackage

// File: rtl/rc_lfsr_step.sv
// Combinational single-step of the Fibonacci-style round LFSR.
// Ports:
//   s_i   - current LFSR state
//   fwd_o - state after one forward step
//   bwd_o - state after one backward step (only with RC_SEQ_INVERSE_EN)
// Build option: RC_SEQ_INVERSE_EN compiles in the backward step.
module rc_lfsr_step #(
  parameter int unsigned        LFSR_W   = 8,
  parameter logic [LFSR_W-1:0]  TAP_MASK = 8'hC6
) (
  input  logic [LFSR_W-1:0] s_i,
`ifdef RC_SEQ_INVERSE_EN
  output logic [LFSR_W-1:0] bwd_o,
`endif
  output logic [LFSR_W-1:0] fwd_o
);

  // Shift left, feed tapped parity into bit 0.
  assign fwd_o = {s_i[LFSR_W-2:0], ^(s_i & TAP_MASK)};

`ifdef RC_SEQ_INVERSE_EN
  // Undo the shift; recover the dropped MSB from the feedback bit now in bit 0.
  assign bwd_o = {s_i[0] ^ (^(s_i[LFSR_W-1:1] & TAP_MASK[LFSR_W-2:0])),
                  s_i[LFSR_W-1:1]};
`endif

endmodule

// File: rtl/round_const_seq.sv
// Round-constant sequencer: emits ROUNDS constants per sequence, one per
// handshake, each word being the LFSR state XOR a per-word mask.
// Ports:
//   clk, rstn            - clock, async active-low reset
//   start, inv           - begin a sequence (IDLE only); inv selects reverse order
//   clear                - synchronous abort to IDLE (highest priority)
//   rc_ready             - consumer accepts current constant
//   rc_valid, rc         - constant valid / value
//   rc_round, rc_last    - round index / final-constant flag
//   busy                 - FSM not in IDLE
// Build option: RC_SEQ_INVERSE_EN enables reverse mode (PRE state, backward steps).
module round_const_seq
  import ublock_rc_pkg::*;
#(
  parameter int unsigned                  LFSR_W    = 8,
  parameter int unsigned                  NUM_WORDS = 4,
  parameter int unsigned                  ROUNDS    = 16,
  parameter logic [LFSR_W-1:0]            SEED      = RC_DEF_SEED,
  parameter logic [LFSR_W-1:0]            TAP_MASK  = RC_DEF_TAP_MASK,
  parameter logic [NUM_WORDS*LFSR_W-1:0]  WORD_XOR  = RC_DEF_WORD_XOR
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic                          inv,
  input  logic                          clear,
  input  logic                          rc_ready,
  output logic                          rc_valid,
  output logic [NUM_WORDS*LFSR_W-1:0]   rc,
  output logic [$clog2(ROUNDS)-1:0]     rc_round,
  output logic                          rc_last,
  output logic                          busy
);

  localparam int unsigned     RW       = $clog2(ROUNDS);
  localparam logic [RW-1:0]   LAST_RND = RW'(ROUNDS - 1);

  rc_state_e                      state_q, state_d;
  logic [LFSR_W-1:0]              lfsr_q, lfsr_d;
  logic [RW-1:0]                  round_q, round_d;
  logic                           valid_q, valid_d;
  logic                           last_q, last_d;
  logic                           busy_q, busy_d;
  logic [NUM_WORDS*LFSR_W-1:0]    rc_q, rc_d;
  logic [LFSR_W-1:0]              step_in_c, fwd_c;
  logic                           at_end_c;

`ifdef RC_SEQ_INVERSE_EN
  localparam logic [RW-1:0]   PRE_END = RW'(ROUNDS - 2);
  logic                       inv_q, inv_d;
  logic [LFSR_W-1:0]          bwd_c;
`else
  logic                       unused_inv_c;
  assign unused_inv_c = inv;
`endif

  // In IDLE the stepper sees SEED so its forward output is S_0.
  assign step_in_c = (state_q == ST_IDLE) ? SEED : lfsr_q;

  rc_lfsr_step #(
    .LFSR_W   (LFSR_W),
    .TAP_MASK (TAP_MASK)
  ) u_step (
    .s_i   (step_in_c),
`ifdef RC_SEQ_INVERSE_EN
    .bwd_o (bwd_c),
`endif
    .fwd_o (fwd_c)
  );

  // End of sequence depends on direction of travel.
`ifdef RC_SEQ_INVERSE_EN
  assign at_end_c = inv_q ? (round_q == '0) : (round_q == LAST_RND);
`else
  assign at_end_c = (round_q == LAST_RND);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    round_d = round_q;
`ifdef RC_SEQ_INVERSE_EN
    inv_d   = inv_q;
`endif
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            lfsr_d  = fwd_c;
            round_d = '0;
`ifdef RC_SEQ_INVERSE_EN
            inv_d   = inv;
            state_d = inv ? ST_PRE : ST_RUN;
`else
            state_d = ST_RUN;
`endif
          end
        end
`ifdef RC_SEQ_INVERSE_EN
        // Walk forward to S_(ROUNDS-1) before emitting in reverse.
        ST_PRE: begin
          lfsr_d  = fwd_c;
          round_d = round_q + RW'(1);
          if (round_q == PRE_END) state_d = ST_RUN;
        end
`endif
        ST_RUN: begin
          if (rc_ready) begin
            if (at_end_c) begin
              state_d = ST_IDLE;
            end else begin
`ifdef RC_SEQ_INVERSE_EN
              lfsr_d  = inv_q ? bwd_c : fwd_c;
              round_d = inv_q ? (round_q - RW'(1)) : (round_q + RW'(1));
`else
              lfsr_d  = fwd_c;
              round_d = round_q + RW'(1);
`endif
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE);
`ifdef RC_SEQ_INVERSE_EN
    last_d  = valid_d && (inv_d ? (round_d == '0) : (round_d == LAST_RND));
`else
    last_d  = valid_d && (round_d == LAST_RND);
`endif
    rc_d = '0;
    if (valid_d) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        rc_d[i*LFSR_W +: LFSR_W] = lfsr_d ^ WORD_XOR[i*LFSR_W +: LFSR_W];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      lfsr_q  <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      rc_q    <= '0;
`ifdef RC_SEQ_INVERSE_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      round_q <= round_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      rc_q    <= rc_d;
`ifdef RC_SEQ_INVERSE_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign rc_valid = valid_q;
  assign rc       = rc_q;
  assign rc_round = round_q;
  assign rc_last  = last_q;
  assign busy     = busy_q;

endmodule

// File: doc/round_const_seq.md
ROUND_CONST_SEQ -- requirements
Module: round_const_seq

Interface
REQ-001 Parameter LFSR_W, default 8, LFSR and per-word constant width (>=4).
REQ-002 Parameter NUM_WORDS, default 4, number of constant words emitted per round.
REQ-003 Parameter ROUNDS, default 16, rounds per sequence (>=2).
REQ-004 Parameter SEED, default 8'h6C, LFSR load value.
REQ-005 Parameter TAP_MASK, default 8'hC6, feedback taps; bit LFSR_W-1 SHALL be 1.
REQ-006 Parameter WORD_XOR, default {8'h40,8'h54,8'h11,8'h05}, per-word inversion masks; the top slice belongs to word NUM_WORDS-1.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 rstn  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
REQ-010 inv  in  1  mode sampled with start: 0 forward rounds, 1 reverse rounds.
REQ-011 clear  in  1  synchronous abort to IDLE.
REQ-012 rc_ready  in  1  consumer accepts the current constant.
REQ-013 rc_valid  out  1  rc holds a valid round constant.
REQ-014 rc  out  NUM_WORDS*LFSR_W  round constant; word i = state XOR WORD_XOR slice i.
REQ-015 rc_round  out  $clog2(ROUNDS)  round index of rc.
REQ-016 rc_last  out  1  high with rc_valid on the final constant.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 Forward step: next = {s[LFSR_W-2:0], parity(s & TAP_MASK)}.
REQ-019 Backward step: prev[LFSR_W-2:0] = s[LFSR_W-1:1]; prev[LFSR_W-1] = s[0] XOR parity(s[LFSR_W-1:1] & TAP_MASK[LFSR_W-2:0]).
REQ-020 Define S_k = forward step applied k+1 times to SEED; the round-k constant is derived from S_k.
REQ-021 FSM states are IDLE, PRE and RUN.
REQ-022 IDLE to RUN: start with inv=0 loads state=S_0 and rc_round=0; rc_valid rises the next cycle.
REQ-023 IDLE to PRE: start with inv=1 loads S_0, then performs ROUNDS-1 forward steps with rc_valid low.
REQ-024 PRE to RUN: on completion of PRE, rc_round=ROUNDS-1; the first valid appears exactly ROUNDS cycles after start.
REQ-025 In RUN, rc, rc_round and rc_last SHALL hold stable while rc_valid && !rc_ready.
REQ-026 On a RUN handshake with !rc_last, state steps (forward, or backward when inv) and rc_round increments (or decrements when inv), giving one constant per cycle under continuous ready.
REQ-027 rc_last = rc_valid && rc_round==ROUNDS-1 (forward) or rc_round==0 (inverse).
REQ-028 A handshake on rc_last returns the FSM to IDLE with rc_valid low the next cycle; a start in that same cycle is ignored.
REQ-029 start while busy is ignored; clear has priority over start and handshake and forces IDLE next cycle.
REQ-030 rc_round never wraps; no LFSR step occurs in IDLE.

Reset
REQ-031 rstn low forces IDLE, state=0, rc_round=0, rc_valid=0, rc_last=0, busy=0 immediately, including mid-sequence.
REQ-032 The first start after reset release behaves identically to the first start of REQ-022/REQ-023.

Configuration
REQ-033 Macro RC_SEQ_INVERSE_EN defined: inverse mode, the PRE state and backward stepping are compiled in.
REQ-034 Macro absent: inv is ignored (treated 0), PRE and backward-step logic are absent, and forward behaviour is unchanged.

Structure
REQ-035 Package ublock_rc_pkg SHALL hold the FSM state enum and the default SEED, TAP_MASK and WORD_XOR constants.
REQ-036 Combinational sub-module rc_lfsr_step (parameters LFSR_W and TAP_MASK) SHALL provide both the forward and backward next-state values.

Verification
REQ-037 Forward, default params, ready=1: start,inv=0 -> next cycle rc=32'h988CC9DD, round 0; then state 0xB0 (round 1) and 0x61 (round 2).
REQ-038 Forward full run: 16 constants, rc_last only on round 15, busy low the cycle after, then 16 reverse-mode constants exactly equal the forward list reversed, first valid 16 cycles after start.
REQ-039 Backpressure: rc_ready held low 5 cycles at round 3 -> rc and rc_round stable, no step; resumes with round 4.
REQ-040 clear at round 7 -> IDLE next cycle, rc_valid=0; a new start restarts at 32'h988CC9DD.
REQ-041 rstn pulsed low during PRE -> all outputs 0 immediately; start issued during busy -> no effect.
REQ-042 Build without RC_SEQ_INVERSE_EN, start,inv=1 -> forward sequence, first valid one cycle after start.
